// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the
// flag layout used by the P register. Pure declarations, no logic, so the
// datapath, the nibble adjuster and the execute stage all agree on encodings.
package alu_pkg;

  // Opcodes carried on alu_ctrl
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SR  = 4'b0100;
  localparam logic [3:0] OP_SL  = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_ROR = 4'b0111;
  localparam logic [3:0] OP_ROL = 4'b1000;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DADJ = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  // Bit positions of the ALU flags inside the processor's P register
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Registered flag set held alongside the result
  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } alu_flags_t;

  // ADD and SUB are the only ops that take the decimal-adjust path
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// bcd_nibble_adj: one-digit BCD add/subtract with decimal correction.
// Latency: combinational; the caller iterates it one nibble per cycle.
// Backpressure: none; pure function of its inputs.
module bcd_nibble_adj (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       sub,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] sum;
  logic [5:0] diff;

  // Add: a+b+c, corrected by +6 above 9. Sub: a-b-borrow, corrected by +10 when negative.
  // For sub, c_in = 1 means "no borrow", so the borrow subtracted is ~c_in.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    diff  = {2'b00, a} - {2'b00, b} - {5'b00000, ~c_in};
    s     = 4'h0;
    c_out = 1'b0;
    if (sub) begin
      if (diff[5]) begin
        s     = diff[3:0] + 4'd10;
        c_out = 1'b0;
      end else begin
        s     = diff[3:0];
        c_out = 1'b1;
      end
    end else begin
      if (sum > 5'd9) begin
        s     = sum[3:0] + 4'd6;
        c_out = 1'b1;
      end else begin
        s     = sum[3:0];
        c_out = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle binary/BCD ALU with registered result and N/V/Z/C flags.
// Latency: done 2 edges after accept for binary/logic/illegal ops, 2 + NIBBLES for decimal ADD/SUB.
// Backpressure: alu_start is only taken in IDLE or DONE; while busy it is ignored, not queued.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             alu_start,
  input  logic [3:0]       alu_ctrl,
  input  logic             alu_decimal,
  input  logic [WIDTH-1:0] alu_AI,
  input  logic [WIDTH-1:0] alu_BI,
  input  logic             alu_carry_in,
  output logic             alu_busy,
  output logic             alu_done,
  output logic [WIDTH-1:0] alu_Y,
  output logic             alu_carry_out,
  output logic             alu_overflow,
  output logic             alu_zero,
  output logic             alu_neg
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  alu_state_t       state, state_nxt;
  logic             accept;

  // Operands captured at accept; later input changes do not disturb the op
  logic [3:0]       op_q;
  logic             dec_q;
  logic             cin_q;
  logic [WIDTH-1:0] a_q, b_q;

  // Binary datapath results, meaningful in EXEC
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] bin_y;
  logic             bin_c, bin_v;
  logic             go_dadj;

  // Decimal-adjust iteration state
  logic [CW-1:0]    nib_cnt;
  logic             last_nib;
  logic             c_run;
  logic             v_hold;
  logic [WIDTH-1:0] dec_y, dec_y_nxt;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_c;

  alu_flags_t       flags_q;

  assign accept   = alu_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign go_dadj  = dec_q && is_arith(op_q);
  assign last_nib = (nib_cnt == CW'(NIBBLES - 1));

  assign alu_carry_out = flags_q.c;
  assign alu_overflow  = flags_q.v;
  assign alu_zero      = flags_q.z;
  assign alu_neg       = flags_q.n;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    alu_busy  = 1'b0;
    alu_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (alu_start) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_busy  = 1'b1;
        state_nxt = go_dadj ? ST_DADJ : ST_DONE;
      end
      ST_DADJ: begin
        alu_busy = 1'b1;
        if (last_nib) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        alu_done  = 1'b1;
        state_nxt = alu_start ? ST_EXEC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SUB reuses the adder with B inverted; carry_in then acts as "no borrow"
  assign b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
  assign sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};

  // Binary result and carry/overflow for every opcode
  always_comb begin
    bin_y = a_q;
    bin_c = cin_q;
    bin_v = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        bin_y = sum[WIDTH-1:0];
        bin_c = sum[WIDTH];
        bin_v = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_OR:  bin_y = a_q | b_q;
      OP_XOR: bin_y = a_q ^ b_q;
      OP_AND: bin_y = a_q & b_q;
      OP_SR: begin
        bin_y = {1'b0, a_q[WIDTH-1:1]};
        bin_c = a_q[0];
      end
      OP_SL: begin
        bin_y = {a_q[WIDTH-2:0], 1'b0};
        bin_c = a_q[WIDTH-1];
      end
      OP_ROR: begin
        bin_y = {cin_q, a_q[WIDTH-1:1]};
        bin_c = a_q[0];
      end
      OP_ROL: begin
        bin_y = {a_q[WIDTH-2:0], cin_q};
        bin_c = a_q[WIDTH-1];
      end
      default: begin
        // Illegal opcode: pass A through, carry_in passes to C
        bin_y = a_q;
        bin_c = cin_q;
      end
    endcase
  end

  // One shared nibble adjuster, stepped LSB first by nib_cnt
  assign nib_a = a_q[{nib_cnt, 2'b00} +: 4];
  assign nib_b = b_q[{nib_cnt, 2'b00} +: 4];

  bcd_nibble_adj u_nib (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (c_run),
    .sub   (op_q == OP_SUB),
    .s     (nib_s),
    .c_out (nib_c)
  );

  // Merge the current adjusted digit into the accumulating decimal result
  always_comb begin
    dec_y_nxt = dec_y;
    dec_y_nxt[{nib_cnt, 2'b00} +: 4] = nib_s;
  end

  // Operand capture, decimal iteration and result/flag registers (written only on entry to DONE)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= OP_ADD;
      dec_q   <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      nib_cnt <= '0;
      c_run   <= 1'b0;
      v_hold  <= 1'b0;
      dec_y   <= '0;
      alu_Y   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= alu_ctrl;
        dec_q <= alu_decimal;
        cin_q <= alu_carry_in;
        a_q   <= alu_AI;
        b_q   <= alu_BI;
      end
      case (state)
        ST_EXEC: begin
          nib_cnt <= '0;
          c_run   <= cin_q;
          v_hold  <= bin_v;
          dec_y   <= '0;
          if (!go_dadj) begin
            alu_Y   <= bin_y;
            flags_q <= {bin_y[WIDTH-1], bin_v, ~|bin_y, bin_c};
          end
        end
        ST_DADJ: begin
          nib_cnt <= nib_cnt + CW'(1);
          c_run   <= nib_c;
          dec_y   <= dec_y_nxt;
          if (last_nib) begin
            // V comes from the binary sum; N and Z from the adjusted digits
            alu_Y   <= dec_y_nxt;
            flags_q <= {dec_y_nxt[WIDTH-1], v_hold, ~|dec_y_nxt, nib_c};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH 8 and 16: directed ops checked against an
// arithmetic reference model, with latency, busy, hold and reset behaviour.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  ctrl;
  logic        dec;
  logic [15:0] a, b;
  logic        cin;
  logic        start8, start16;

  logic        busy8, done8, c8, v8, z8, n8;
  logic [7:0]  y8;
  logic        busy16, done16, c16, v16, z16, n16;
  logic [15:0] y16;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .alu_start(start8), .alu_ctrl(ctrl),
    .alu_decimal(dec), .alu_AI(a[7:0]), .alu_BI(b[7:0]), .alu_carry_in(cin),
    .alu_busy(busy8), .alu_done(done8), .alu_Y(y8), .alu_carry_out(c8),
    .alu_overflow(v8), .alu_zero(z8), .alu_neg(n8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .resetn(resetn), .alu_start(start16), .alu_ctrl(ctrl),
    .alu_decimal(dec), .alu_AI(a), .alu_BI(b), .alu_carry_in(cin),
    .alu_busy(busy16), .alu_done(done16), .alu_Y(y16), .alu_carry_out(c16),
    .alu_overflow(v16), .alu_zero(z16), .alu_neg(n16)
  );

  logic [15:0] y_o[2];
  logic [3:0]  f_o[2];
  logic        done_o[2], busy_o[2];

  always_comb begin
    y_o[0] = {8'h00, y8};  f_o[0] = {n8, v8, z8, c8};
    y_o[1] = y16;          f_o[1] = {n16, v16, z16, c16};
    done_o[0] = done8;     busy_o[0] = busy8;
    done_o[1] = done16;    busy_o[1] = busy16;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          d;
    int          t0;
    int          cyc;
    logic [15:0] y;
    logic [3:0]  f;   // {N,V,Z,C}
  } exp_t;

  exp_t        q[$];
  logic [15:0] hold_y[2];
  logic [3:0]  hold_f[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint bcd_val(input longint x, input int w);
    longint r = 0, p = 1;
    for (int i = 0; i < w / 4; i++) begin
      r += ((x >> (4 * i)) & 15) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic longint bcd_enc(input longint t, input int w);
    longint r = 0, v = t;
    for (int i = 0; i < w / 4; i++) begin
      r |= (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction

  // Reference: plain integer arithmetic; decimal ops done on decimal values
  function automatic exp_t model(input int w, input logic [3:0] op, input bit dm,
                                 input logic [15:0] av, input logic [15:0] bv, input bit ci);
    exp_t   e;
    longint m, half, x, bb, be, s, sa, sb, t, pw, yy;
    bit     c, v;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    x    = longint'(av) & m;
    bb   = longint'(bv) & m;
    c    = ci;
    v    = 1'b0;
    yy   = x;
    case (op)
      4'd0, 4'd6: begin
        be = (op == 4'd6) ? (~bb & m) : bb;
        s  = x + be + longint'(ci);
        yy = s & m;
        c  = s[w];
        sa = (x >= half) ? x - 2 * half : x;
        sb = (be >= half) ? be - 2 * half : be;
        t  = sa + sb + longint'(ci);
        v  = (t >= half) || (t < -half);
        if (dm) begin
          pw = 1;
          for (int i = 0; i < w / 4; i++) pw *= 10;
          if (op == 4'd0) begin
            t = bcd_val(x, w) + bcd_val(bb, w) + longint'(ci);
            c = (t >= pw);
            t = t % pw;
          end else begin
            t = bcd_val(x, w) - bcd_val(bb, w) - longint'(!ci);
            c = (t >= 0);
            if (t < 0) t += pw;
          end
          yy = bcd_enc(t, w);
        end
      end
      4'd1: yy = x | bb;
      4'd2: yy = x ^ bb;
      4'd3: yy = x & bb;
      4'd4: begin yy = x >> 1;                             c = x[0];   end
      4'd5: begin yy = (x << 1) & m;                       c = x[w-1]; end
      4'd7: begin yy = (x >> 1) | (longint'(ci) << (w-1)); c = x[0];   end
      4'd8: begin yy = ((x << 1) & m) | longint'(ci);      c = x[w-1]; end
      default: yy = x;
    endcase
    e.d   = 0;
    e.t0  = 0;
    e.cyc = 0;
    e.y   = 16'(yy);
    e.f   = {yy[w-1], v, (yy == 0), c};
    return e;
  endfunction

  // Compare process: every negedge, per DUT, check done timing, values, hold and busy
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      for (int d = 0; d < 2; d++) begin
        hold_y[d] = '0;
        hold_f[d] = '0;
        chk("reset_y", 32'(y_o[d]), 32'h0);
        chk("reset_flags", 32'(f_o[d]), 32'h0);
        chk("reset_busy", 32'(busy_o[d]), 32'h0);
        chk("reset_done", 32'(done_o[d]), 32'h0);
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (done_o[d]) begin
          if (q.size() == 0 || q[0].d != d) begin
            chk("unexpected_done", 32'h1, 32'h0);
          end else begin
            e = q.pop_front();
            chk("latency", 32'(cyc), 32'(e.cyc));
            chk("result_y", 32'(y_o[d]), 32'(e.y));
            chk("flags_nvzc", 32'(f_o[d]), 32'(e.f));
            hold_y[d] = e.y;
            hold_f[d] = e.f;
          end
        end else begin
          chk("held_y", 32'(y_o[d]), 32'(hold_y[d]));
          chk("held_flags", 32'(f_o[d]), 32'(hold_f[d]));
          if (q.size() > 0 && q[0].d == d) begin
            chk("busy", 32'(busy_o[d]), 32'(cyc > q[0].t0));
            if (cyc >= q[0].cyc) begin
              chk("missing_done", 32'h0, 32'h1);
              void'(q.pop_front());
            end
          end else begin
            chk("busy_idle", 32'(busy_o[d]), 32'h0);
          end
        end
      end
    end
  end

  // Present one op to DUT d (called just after a negedge) and record its expectation
  task automatic issue(input int d, input logic [3:0] op, input bit dm,
                       input logic [15:0] av, input logic [15:0] bv, input bit ci);
    int   w;
    exp_t e;
    w = (d == 0) ? 8 : 16;
    ctrl = op; dec = dm; a = av; b = bv; cin = ci;
    start8  = (d == 0);
    start16 = (d == 1);
    e     = model(w, op, dm, av, bv, ci);
    e.d   = d;
    e.t0  = cyc;
    e.cyc = cyc + 2 + ((dm && (op == 4'd0 || op == 4'd6)) ? w / 4 : 0);
    q.push_back(e);
  endtask

  task automatic run(input int d, input logic [3:0] op, input bit dm,
                     input logic [15:0] av, input logic [15:0] bv, input bit ci);
    @(negedge clk);
    issue(d, op, dm, av, bv, ci);
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    resetn = 1'b0; start8 = 1'b0; start16 = 1'b0;
    ctrl = 4'd0; dec = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Hand-computed values pinning the reference model
    e = model(8, 4'd0, 0, 16'h50, 16'h50, 0);     chk("pin_add_y", 32'(e.y), 32'hA0);  chk("pin_add_f", 32'(e.f), 32'b1100);
    e = model(8, 4'd0, 1, 16'h58, 16'h46, 1);     chk("pin_dadd_y", 32'(e.y), 32'h05); chk("pin_dadd_f", 32'(e.f), 32'b0101);
    e = model(8, 4'd6, 1, 16'h12, 16'h21, 1);     chk("pin_dsub_y", 32'(e.y), 32'h91); chk("pin_dsub_f", 32'(e.f), 32'b1000);
    e = model(8, 4'd4, 0, 16'h01, 16'h00, 0);     chk("pin_sr_y", 32'(e.y), 32'h00);   chk("pin_sr_f", 32'(e.f), 32'b0011);
    e = model(8, 4'd8, 0, 16'h80, 16'h00, 1);     chk("pin_rol_y", 32'(e.y), 32'h01);  chk("pin_rol_f", 32'(e.f), 32'b0001);
    e = model(8, 4'd3, 0, 16'hF0, 16'h0F, 1);     chk("pin_and_y", 32'(e.y), 32'h00);  chk("pin_and_f", 32'(e.f), 32'b0011);
    e = model(16, 4'd0, 1, 16'h9999, 16'h0001, 0); chk("pin_d16_y", 32'(e.y), 32'h0000); chk("pin_d16_f", 32'(e.f), 32'b0011);

    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    // WIDTH 8 directed ops
    run(0, 4'd0, 0, 16'h50, 16'h50, 0);
    run(0, 4'd0, 1, 16'h58, 16'h46, 1);
    run(0, 4'd6, 1, 16'h12, 16'h21, 1);
    run(0, 4'd4, 0, 16'h01, 16'h00, 0);
    run(0, 4'd8, 0, 16'h80, 16'h00, 1);
    run(0, 4'd3, 0, 16'hF0, 16'h0F, 1);
    run(0, 4'd1, 0, 16'hA5, 16'h5A, 0);
    run(0, 4'd2, 0, 16'hFF, 16'h0F, 1);
    run(0, 4'd5, 0, 16'h81, 16'h00, 0);
    run(0, 4'd7, 0, 16'h02, 16'h00, 0);
    run(0, 4'd6, 0, 16'h10, 16'h20, 1);
    run(0, 4'hB, 0, 16'h3C, 16'h00, 1);
    run(0, 4'd3, 1, 16'hFF, 16'h81, 0);
    run(0, 4'd0, 1, 16'h99, 16'h01, 0);

    // Back-to-back: each new start lands in the previous op's DONE cycle
    @(negedge clk); issue(0, 4'd0, 0, 16'h11, 16'h22, 0);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); issue(0, 4'd6, 0, 16'h40, 16'h41, 1);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); issue(0, 4'd2, 0, 16'hC3, 16'h3C, 0);
    @(negedge clk); start8 = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);

    // Starts and operand changes during EXEC/DADJ must be ignored
    @(negedge clk); issue(0, 4'd0, 1, 16'h27, 16'h15, 0);
    repeat (3) begin
      @(negedge clk);
      ctrl = 4'd2; dec = 1'b0; a = 16'hFF; b = 16'hFF; cin = 1'b1; start8 = 1'b1;
    end
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of DADJ aborts with no done pulse
    @(negedge clk); issue(0, 4'd6, 1, 16'h45, 16'h17, 1);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'h0);
    chk("abort_done", 32'(done8), 32'h0);
    chk("abort_y", 32'(y8), 32'h0);
    chk("abort_flags", 32'({n8, v8, z8, c8}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(negedge clk);

    // WIDTH 16
    run(1, 4'd0, 1, 16'h9999, 16'h0001, 0);
    run(1, 4'd6, 1, 16'h0000, 16'h0001, 1);
    run(1, 4'd0, 0, 16'h7FFF, 16'h0001, 0);
    run(1, 4'd7, 0, 16'h0001, 16'h0000, 1);
    run(1, 4'hC, 0, 16'h1234, 16'h5678, 0);
    run(1, 4'd0, 1, 16'h1234, 16'h5678, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the processor's combinational ALU. It accepts one operation per start/done handshake, supports binary and BCD (decimal-mode) add/subtract, logic operations, shifts and rotates at any WIDTH that is a multiple of 4, and returns registered result and N/V/Z/C flags. It sits between the control unit's execute stage and the P register / accumulator write-back path.

## Interface
Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 and at least 8
- NIBBLES, WIDTH/4, derived localparam; number of decimal-adjust cycles

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- alu_start  input  1  request; sampled only in IDLE or DONE
- alu_ctrl  input  4  opcode (see Operation)
- alu_decimal  input  1  BCD mode for ADD/SUB
- alu_AI  input  WIDTH  operand A
- alu_BI  input  WIDTH  operand B
- alu_carry_in  input  1  carry in (for SUB: 1 = no borrow)
- alu_busy  output  1  high in EXEC and DADJ
- alu_done  output  1  one-cycle pulse; result valid
- alu_Y  output  WIDTH  result, held until next accept
- alu_carry_out, alu_overflow, alu_zero, alu_neg  output  1 each  C/V/Z/N flags, held with alu_Y

## Operation
- Opcodes: ADD 0000, OR 0001, XOR 0010, AND 0011, SR 0100, SL 0101, SUB 0110, ROR 0111, ROL 1000; all others illegal.
- Accept: alu_start high in IDLE or DONE latches ctrl, decimal, AI, BI, carry_in; input changes after the accept are ignored. alu_start in EXEC/DADJ is ignored (not queued).
- States: IDLE -> EXEC on accept. EXEC -> DADJ if decimal and op is ADD/SUB, else -> DONE. DADJ runs NIBBLES cycles, LSB nibble first, then -> DONE. DONE -> EXEC on accept, else -> IDLE.
- ADD: {C,Y} = A + B + Cin. SUB: {C,Y} = A + ~B + Cin. Width WIDTH+1; V = signed overflow of the binary result.
- Decimal adjust, per nibble with running carry: ADD: s = a + b + c; if s > 9 then s += 6 and c = 1, else c = 0. SUB: d = a - b - ~c; if d < 0 then d += 10 and c = 0, else c = 1. Final C from the last nibble. V is taken from the binary result; N and Z from the adjusted result. Non-BCD nibbles produce defined but unspecified values (no error flag).
- OR/XOR/AND: V = 0; C = carry_in (passed through).
- SR: Y = {0, A[W-1:1]}, C = A[0]. SL: Y = {A[W-2:0], 0}, C = A[W-1]. ROR: Y = {Cin, A[W-1:1]}, C = A[0]. ROL: Y = {A[W-2:0], Cin}, C = A[W-1]. V = 0 for all four.
- Every op: Z = (Y == 0), N = Y[W-1].
- Illegal opcode: Y = A, C = carry_in, V = 0, N/Z from Y; completes with binary latency.

## Timing
- Reset (async assert, sync release): state IDLE; alu_Y = 0; all flags, alu_busy and alu_done = 0.
- Latency, counted in rising edges after the edge that samples alu_start: binary/logic/illegal 2 (alu_done high after edge 2); decimal ADD/SUB 2 + NIBBLES (4 at WIDTH = 8).
- Outputs update only on entry to DONE; stable otherwise.
- Back-to-back: accept in the DONE cycle gives throughput of one op per 2 cycles (binary).
- Reset mid-operation: abort immediately; no alu_done pulse; outputs return to reset values.

## Structure
- alu_pkg: opcode localparams, state encoding (IDLE, EXEC, DADJ, DONE), flag bit indices shared with the P register.
- Sub-module bcd_nibble_adj: combinational single-nibble add/sub adjust (a, b, c_in, sub -> s, c_out), instantiated once and iterated by the DADJ counter.

## Test plan
- WIDTH=8 binary ADD 0x50 + 0x50, Cin 0 -> Y=0xA0, V=1, N=1, Z=0, C=0; done after edge 2.
- Decimal ADD 0x58 + 0x46, Cin 1 -> Y=0x05, C=1; done after edge 4. Decimal SUB 0x12 - 0x21, Cin 1 -> Y=0x91, C=0.
- SR 0x01 -> Y=0x00, Z=1, C=1; ROL 0x80, Cin 1 -> Y=0x01, C=1; AND 0xF0 & 0x0F -> Z=1, C = Cin.
- alu_start pulsed in EXEC/DADJ -> ignored, single done pulse; new start in DONE cycle -> accepted, next done 2 edges later.
- Reset asserted during DADJ -> busy/done/Y/flags go to 0 immediately; no done pulse.
- WIDTH=16 decimal ADD 0x9999 + 0x0001, Cin 0 -> Y=0x0000, C=1, Z=1; done after edge 6.
